// File: rtl/tug_pkg.sv
// Shared types and defaults for the tug-of-war match controller.
// Latency: none (types and constants only); no backpressure, no flow control.
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_N_LIGHTS    = 9;
    localparam int DEF_WIN_SCORE   = 7;
    localparam int DEF_SCORE_W     = 3;
    localparam int DEF_HOLD_CYCLES = 4;

    function automatic int centre_idx(input int n_lights);
        return n_lights / 2;
    endfunction

endpackage

// File: rtl/tug_match_ctrl_press_edge.sv
// Rising-edge detector: one-cycle pulse in the same cycle the level first goes high.
// Latency: pulse is combinational from level; the history register is always enabled.
module press_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/tug_match_ctrl.sv
// Tug-of-war sequencer: moves a one-hot rope on button presses, scores rounds, re-centres.
// Latency: a press moves the rope on the edge that samples it; buttons are never backpressured.
module tug_match_ctrl
    import tug_pkg::*;
#(
    parameter int N_LIGHTS    = DEF_N_LIGHTS,
    parameter int WIN_SCORE   = DEF_WIN_SCORE,
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                L,
    input  logic                R,
    output logic [N_LIGHTS-1:0] lights,
    output logic [SCORE_W-1:0]  score_l,
    output logic [SCORE_W-1:0]  score_r,
    output logic [1:0]          round_win,
    output logic                match_over
);

    localparam int POS_W  = $clog2(N_LIGHTS);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [POS_W-1:0]   CENTRE   = POS_W'(centre_idx(N_LIGHTS));
    localparam logic [POS_W-1:0]   POS_MAX  = POS_W'(N_LIGHTS - 1);
    localparam logic [HOLD_W-1:0]  HOLD_END = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

    logic pl;
    logic pr;

    press_edge u_edge_l (.clk(clk), .reset(reset), .level(L), .pulse(pl));
    press_edge u_edge_r (.clk(clk), .reset(reset), .level(R), .pulse(pr));

    state_t              state,       state_nxt;
    logic [POS_W-1:0]    pos,         pos_nxt;
    logic [SCORE_W-1:0]  score_l_nxt, score_r_nxt;
    logic [1:0]          round_win_nxt;
    logic [HOLD_W-1:0]   hold_cnt,    hold_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PLAY;
            pos       <= CENTRE;
            score_l   <= '0;
            score_r   <= '0;
            round_win <= 2'b00;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            pos       <= pos_nxt;
            score_l   <= score_l_nxt;
            score_r   <= score_r_nxt;
            round_win <= round_win_nxt;
            hold_cnt  <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pos_nxt       = pos;
        score_l_nxt   = score_l;
        score_r_nxt   = score_r;
        round_win_nxt = round_win;
        hold_cnt_nxt  = hold_cnt;
        case (state)
            PLAY: begin
                // Simultaneous presses cancel out.
                if (pl && !pr) begin
                    if (pos == POS_MAX) begin
                        score_l_nxt   = score_l + 1'b1;
                        round_win_nxt = 2'b10;
                        hold_cnt_nxt  = '0;
                        state_nxt     = HOLD;
                    end else begin
                        pos_nxt = pos + 1'b1;
                    end
                end else if (pr && !pl) begin
                    if (pos == '0) begin
                        score_r_nxt   = score_r + 1'b1;
                        round_win_nxt = 2'b01;
                        hold_cnt_nxt  = '0;
                        state_nxt     = HOLD;
                    end else begin
                        pos_nxt = pos - 1'b1;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_END) begin
                    if ((round_win[1] && score_l == WIN_VAL) ||
                        (round_win[0] && score_r == WIN_VAL)) begin
                        state_nxt = DONE;
                    end else begin
                        pos_nxt       = CENTRE;
                        round_win_nxt = 2'b00;
                        state_nxt     = PLAY;
                    end
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            DONE: begin
            end
            default: state_nxt = PLAY;
        endcase
    end

    for (genvar i = 0; i < N_LIGHTS; i++) begin : g_decode
        assign lights[i] = (pos == POS_W'(i));
    end

    assign match_over = (state == DONE);

endmodule

// File: tb/tb_tug_match_ctrl.sv
// Directed bench for tug_match_ctrl (WIN_SCORE=2) with a queue-based expected-state scoreboard.
module tb_tug_match_ctrl;

    localparam logic [8:0] C  = 9'b000010000;
    localparam logic [8:0] LE = 9'b100000000;
    localparam logic [8:0] RE = 9'b000000001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       L = 1'b0;
    logic       R = 1'b0;
    logic [8:0] lights;
    logic [2:0] score_l;
    logic [2:0] score_r;
    logic [1:0] round_win;
    logic       match_over;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [8:0] lights;
        logic [2:0] sl;
        logic [2:0] sr;
        logic [1:0] rw;
        logic       mo;
    } exp_t;

    exp_t sb[$];

    tug_match_ctrl #(
        .N_LIGHTS(9), .WIN_SCORE(2), .SCORE_W(3), .HOLD_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .L(L), .R(R),
        .lights(lights), .score_l(score_l), .score_r(score_r),
        .round_win(round_win), .match_over(match_over)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string field,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, got, want);
        end
    endtask

    task automatic cyc(input logic l, input logic r);
        L = l;
        R = r;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle, then compare the DUT against the expectation queued with it.
    task automatic step(input logic l, input logic r, input string tag,
                        input logic [8:0] lt, input logic [2:0] sl, input logic [2:0] sr,
                        input logic [1:0] rw, input logic mo);
        exp_t e;
        sb.push_back('{tag, lt, sl, sr, rw, mo});
        cyc(l, r);
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            cmp(e.tag, "lights",     32'(lights),     32'(e.lights));
            cmp(e.tag, "score_l",    32'(score_l),    32'(e.sl));
            cmp(e.tag, "score_r",    32'(score_r),    32'(e.sr));
            cmp(e.tag, "round_win",  32'(round_win),  32'(e.rw));
            cmp(e.tag, "match_over", 32'(match_over), 32'(e.mo));
        end
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        cyc(0, 0);
        cyc(0, 0);
        step(0, 0, "reset", C, 0, 0, 2'b00, 0);
        reset = 1'b0;

        // A held button counts once
        step(1, 0, "l_first", 9'b000100000, 0, 0, 2'b00, 0);
        cyc(1, 0);
        cyc(1, 0);
        cyc(1, 0);
        step(1, 0, "l_held", 9'b000100000, 0, 0, 2'b00, 0);
        step(0, 0, "l_release", 9'b000100000, 0, 0, 2'b00, 0);

        // Simultaneous presses cancel
        step(0, 1, "r_back", C, 0, 0, 2'b00, 0);
        cyc(0, 0);
        step(1, 1, "both", C, 0, 0, 2'b00, 0);
        cyc(0, 0);

        // Right round win, press ignored in hold, re-centre after 4 cycles
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1);
            cyc(0, 0);
        end
        step(0, 0, "r_edge", RE, 0, 0, 2'b00, 0);
        step(0, 1, "r_win", RE, 0, 1, 2'b01, 0);
        cyc(0, 0);
        step(1, 0, "hold_press", RE, 0, 1, 2'b01, 0);
        step(0, 0, "hold_keep", RE, 0, 1, 2'b01, 0);
        step(0, 0, "recentre", C, 0, 1, 2'b00, 0);

        // Left wins twice -> match over
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0);
            cyc(0, 0);
        end
        step(0, 0, "l_edge", LE, 0, 1, 2'b00, 0);
        step(1, 0, "l_win1", LE, 1, 1, 2'b10, 0);
        cyc(0, 0);
        cyc(0, 0);
        cyc(0, 0);
        step(0, 0, "l_recentre", C, 1, 1, 2'b00, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0);
            cyc(0, 0);
        end
        step(1, 0, "l_win2", LE, 2, 1, 2'b10, 0);
        cyc(0, 0);
        cyc(0, 0);
        step(0, 0, "hold2_end_m1", LE, 2, 1, 2'b10, 0);
        step(0, 0, "match_done", LE, 2, 1, 2'b10, 1);
        step(0, 1, "done_r", LE, 2, 1, 2'b10, 1);
        step(0, 0, "done_idle", LE, 2, 1, 2'b10, 1);
        step(1, 0, "done_l", LE, 2, 1, 2'b10, 1);
        step(0, 0, "done_idle2", LE, 2, 1, 2'b10, 1);

        // Reset out of DONE, then reset in the middle of HOLD
        reset = 1'b1;
        cyc(0, 0);
        reset = 1'b0;
        step(0, 0, "reset_done", C, 0, 0, 2'b00, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1);
            cyc(0, 0);
        end
        step(0, 1, "r_win2", RE, 0, 1, 2'b01, 0);
        cyc(0, 0);
        reset = 1'b1;
        step(0, 0, "reset_hold", C, 0, 0, 2'b00, 0);
        reset = 1'b0;
        step(1, 0, "play_after_reset", 9'b000100000, 0, 0, 2'b00, 0);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
